fir_stream_source: RTL and testbench
====================================

Name: fir_stream_source

Overview:
- Avalon-ST transmitter that feeds the FIR input. Buffers raw 12-bit ADC samples in a small FIFO and drives them to the FIR sink under valid/ready backpressure.
- Owns the filter-select handoff: it drives the `sel` that the downstream variable-saturation stage uses.
- On a select change, it first flushes the FIR delay line with zero beats, then switches `sel`, so no output sample mixes the old and new filter/saturation.

Parameters:
- DATA_WIDTH, 12, sample width on input and Avalon-ST source.
- FIFO_DEPTH, 8, sample FIFO entries; power of two, minimum 2.
- FLUSH_LEN, 64, zero beats sent per select change; must be ≥ FIR tap count; range 1..1023.

Ports:
- clk  in  1  single system clock
- reset_n  in  1  asynchronous active-low reset
- sample_in  in  DATA_WIDTH  two's-complement ADC sample
- sample_valid  in  1  qualifies sample_in for one cycle
- sel_req  in  2  requested filter: 0 flat, 1 low pass, 2 band pass, 3 high pass
- ast_source_data  out  DATA_WIDTH  sample to FIR sink
- ast_source_valid  out  1  beat valid
- ast_source_ready  in  1  FIR ready (ready latency 0)
- ast_source_error  out  2  per-beat error; bit0 = sample(s) dropped before this beat
- sel  out  2  active filter select, fed to the saturation stage
- flushing  out  1  high while zero beats are being emitted
- fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- **Reset:**
  - Asynchronous, active-low. Clears all outputs to 0, including `sel` = 0 and an empty FIFO.
  - Reset mid-operation aborts any flush and discards the FIFO contents.
- **Output register:**
  - The output is a registered skid-free stage. A transfer occurs when `ast_source_valid` && `ast_source_ready`.
  - While valid && !ready, `ast_source_data` and `ast_source_error` hold stable.
  - The output register reloads only when it is empty or a transfer occurs in that cycle.
- **FIFO:**
  - Write on `sample_valid`. Read when the output register loads from the FIFO.
  - Simultaneous read and write while full is allowed and nothing is dropped.
  - Write while full with no read: the sample is dropped and a `drop_pending` flag is set.
  - Pointers wrap modulo FIFO_DEPTH.
- **Latency:** a sample written into an empty FIFO with the output idle appears on `ast_source_valid` 2 cycles later.
- **Error:**
  - The first FIFO-sourced beat loaded after a drop carries `error` = 2'b01; this load clears `drop_pending`.
  - Zero beats always carry 2'b00.
  - Bit1 is reserved and is 0.
- **State machine (STREAM, FLUSH, SWITCH):**
  - STREAM:
    - Loads the output from the FIFO when it is non-empty.
    - If `sel_req` != `sel` and the output register is empty or transferring, latch `target` = `sel_req`, load the flush counter with FLUSH_LEN, and go to FLUSH.
    - A pending select change has priority over FIFO data.
  - FLUSH:
    - `flushing` = 1.
    - Loads zero beats (data 0) into the output register. The counter decrements on each zero-beat transfer.
    - The FIFO keeps accepting writes, but no reads occur.
    - When the last zero beat transfers, go to SWITCH.
    - Changes to `sel_req` during FLUSH are ignored until return to STREAM.
  - SWITCH:
    - One cycle: `sel` <= `target`, `flushing` = 0, output invalid. Next state is STREAM.
    - If `sel_req` differs from the new `sel`, the next STREAM cycle starts a new flush.
- **Widths:** data passes through unmodified, with no arithmetic on samples. The flush counter is 10 bits.

Decomposition:
- **Shared package `fir_stream_pkg`:**
  - State enum {STREAM, FLUSH, SWITCH}.
  - Filter-select constants SEL_FLAT=0, SEL_LOWPASS=1, SEL_BANDPASS=2, SEL_HIGHPASS=3.
  - ERR_DROP = 2'b01.
- **Sub-module `fir_stream_fifo`:** synchronous FIFO with parameterised depth and width, and outputs full, empty and level. All other logic stays in the top module.

Test Plan:
- **Reset:** reset_n low mid-stream -> all outputs 0 and `sel` = 0 immediately. After release, 3 samples 0x123, 0x7FF, 0x800 with ready=1 -> emitted in order, first one 2 cycles after its write, error 0.
- **Backpressure:** ready=0 for 10 cycles while 8 samples arrive -> valid held with data stable, `fifo_level` = 7 (one sample in the output register). Ready=1 -> all 8 emitted in order with no gaps.
- **Overflow:** ready=0 while 10 samples arrive (FIFO_DEPTH=8) -> 1 sample dropped. After resume, the first beat loaded from the FIFO after the drop has error = 2'b01; all others 2'b00.
- **Select change:** `sel_req` 0->2 while streaming, ready=1 -> exactly 64 zero beats with `flushing`=1, then `sel`=2. Buffered samples then resume in order.
- **Flush under backpressure:** ready toggling 50% during flush -> still exactly 64 zero transfers, with data 0 held stable on stalled beats.
- **Select change during flush:** `sel_req` changes 0->1, then to 3 mid-flush -> `sel` becomes 1 after 64 zeros, then a second flush of 64 zeros, then `sel`=3.

Source files
------------

// File: rtl/fir_stream_pkg.sv
// Shared types and constants for the FIR input stream source.
package fir_stream_pkg;

    // Stream source control states.
    typedef enum logic [1:0] {
        STREAM = 2'd0,
        FLUSH  = 2'd1,
        SWITCH = 2'd2
    } state_t;

    // Filter select encodings driven on sel.
    localparam logic [1:0] SEL_FLAT     = 2'd0;
    localparam logic [1:0] SEL_LOWPASS  = 2'd1;
    localparam logic [1:0] SEL_BANDPASS = 2'd2;
    localparam logic [1:0] SEL_HIGHPASS = 2'd3;

    // Per-beat error code: one or more samples were dropped before this beat.
    localparam logic [1:0] ERR_DROP = 2'b01;

    // Width of the zero-beat flush counter.
    localparam int unsigned FLUSH_CNT_W = 10;

endpackage

// File: rtl/fir_stream_fifo.sv
// Synchronous sample FIFO with occupancy, full and empty flags.
// Read data is presented combinationally from the read pointer.
module fir_stream_fifo
    import fir_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign level   = count;

endmodule

// File: rtl/fir_stream_source.sv
// Avalon-ST source feeding the FIR sink. Buffers ADC samples, drives them
// out under backpressure, and owns the filter-select handoff: a select
// change first pushes FLUSH_LEN zero beats through the FIR delay line and
// only then switches sel, so no output sample mixes two filters.
module fir_stream_source
    import fir_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FLUSH_LEN  = 64
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [DATA_WIDTH-1:0]         sample_in,
    input  logic                          sample_valid,
    input  logic [1:0]                    sel_req,
    output logic [DATA_WIDTH-1:0]         ast_source_data,
    output logic                          ast_source_valid,
    input  logic                          ast_source_ready,
    output logic [1:0]                    ast_source_error,
    output logic [1:0]                    sel,
    output logic                          flushing,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_LEN);
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LAST = FLUSH_CNT_W'(1);

    state_t                   state_q;
    state_t                   state_d;

    logic [DATA_WIDTH-1:0]    data_q;
    logic [1:0]               err_q;
    logic                     valid_q;
    logic [1:0]               sel_q;
    logic [1:0]               target_q;
    logic [FLUSH_CNT_W-1:0]   cnt_q;
    logic                     drop_q;

    logic [DATA_WIDTH-1:0]    fifo_rd_data;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_wr;
    logic                     fifo_rd;

    logic                     xfer;
    logic                     can_load;
    logic                     start_flush;
    logic                     load_fifo;
    logic                     load_zero;
    logic                     cnt_dec;
    logic                     drop_set;

    fir_stream_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (fifo_wr),
        .wr_data (sample_in),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign xfer     = valid_q && ast_source_ready;
    assign can_load = !valid_q || ast_source_ready;

    // A write into a full FIFO still succeeds when a read frees a slot in
    // the same cycle; only a write with no accompanying read is dropped.
    assign fifo_rd  = load_fifo;
    assign fifo_wr  = sample_valid && (!fifo_full || fifo_rd);
    assign drop_set = sample_valid && fifo_full && !fifo_rd;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= STREAM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and load decisions. cnt_q counts zero beats still to be
    // transferred; when the output slot frees up a new zero is loaded only
    // if at least one more transfer remains after this cycle.
    always_comb begin
        state_d     = state_q;
        start_flush = 1'b0;
        load_fifo   = 1'b0;
        load_zero   = 1'b0;
        cnt_dec     = 1'b0;
        unique case (state_q)
            STREAM: begin
                if (can_load) begin
                    if (sel_req != sel_q) begin
                        start_flush = 1'b1;
                        state_d     = FLUSH;
                    end else if (!fifo_empty) begin
                        load_fifo = 1'b1;
                    end
                end
            end
            FLUSH: begin
                cnt_dec = xfer;
                if (xfer && (cnt_q == FLUSH_LAST)) begin
                    state_d = SWITCH;
                end else if (can_load) begin
                    load_zero = 1'b1;
                end
            end
            SWITCH: begin
                state_d = STREAM;
            end
            default: begin
                state_d = STREAM;
            end
        endcase
    end

    // Output register: reloads only when empty or transferring, holds otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= '0;
        end else begin
            if (load_fifo) begin
                valid_q <= 1'b1;
                data_q  <= fifo_rd_data;
                err_q   <= drop_q ? ERR_DROP : 2'b00;
            end else if (load_zero) begin
                valid_q <= 1'b1;
                data_q  <= '0;
                err_q   <= '0;
            end else if (xfer) begin
                valid_q <= 1'b0;
            end
        end
    end

    // Drop tracking: set on a lost sample, cleared by the next FIFO-sourced load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_q <= 1'b0;
        end else begin
            if (load_fifo) begin
                drop_q <= 1'b0;
            end
            if (drop_set) begin
                drop_q <= 1'b1;
            end
        end
    end

    // Flush bookkeeping and the select handoff.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            target_q <= SEL_FLAT;
            sel_q    <= SEL_FLAT;
        end else begin
            if (start_flush) begin
                cnt_q    <= FLUSH_INIT;
                target_q <= sel_req;
            end else if (cnt_dec) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (state_q == SWITCH) begin
                sel_q <= target_q;
            end
        end
    end

    assign ast_source_data  = data_q;
    assign ast_source_valid = valid_q;
    assign ast_source_error = err_q;
    assign sel              = sel_q;
    assign flushing         = (state_q == FLUSH);

endmodule

// File: tb/tb_fir_stream_source.sv
// Self-checking bench for fir_stream_source: table-driven latency vectors,
// directed backpressure/overflow/select-change sequences, and randomized
// traffic checked by a queue-based stream model.
module tb_fir_stream_source;
    import fir_stream_pkg::*;

    localparam int unsigned DW    = 12;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned FLEN  = 64;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [DW-1:0] sample_in = '0;
    logic          sample_valid = 1'b0;
    logic [1:0]    sel_req = SEL_FLAT;
    logic [DW-1:0] ast_source_data;
    logic          ast_source_valid;
    logic          ast_source_ready = 1'b1;
    logic [1:0]    ast_source_error;
    logic [1:0]    sel;
    logic          flushing;
    logic [3:0]    fifo_level;

    always #5 clk = ~clk;

    fir_stream_source #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .FLUSH_LEN  (FLEN)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .sample_in        (sample_in),
        .sample_valid     (sample_valid),
        .sel_req          (sel_req),
        .ast_source_data  (ast_source_data),
        .ast_source_valid (ast_source_valid),
        .ast_source_ready (ast_source_ready),
        .ast_source_error (ast_source_error),
        .sel              (sel),
        .flushing         (flushing),
        .fifo_level       (fifo_level)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    err;
    } beat_t;

    typedef struct {
        logic          sv;
        logic [DW-1:0] s;
        logic          rdy;
        logic          ev;
        logic [DW-1:0] ed;
        logic [3:0]    el;
    } vec_t;

    beat_t         exp_q[$];
    beat_t         mon_b;
    int            checks = 0;
    int            errors = 0;
    int            zeros_total = 0;
    int            data_total = 0;
    int            sent_total = 0;
    int            zrun = 0;
    logic [1:0]    prev_sel = SEL_FLAT;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] held_data = '0;
    logic [1:0]    held_err = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input logic [1:0] e);
        beat_t b;
        b.data = d;
        b.err  = e;
        exp_q.push_back(b);
    endtask

    function automatic logic [DW-1:0] rnd_sample();
        return DW'($urandom_range(1, (1 << DW) - 1));
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_valid"}, 32'(ast_source_valid), 0);
        chk({tag, "_data"}, 32'(ast_source_data), 0);
        chk({tag, "_err"}, 32'(ast_source_error), 0);
        chk({tag, "_sel"}, 32'(sel), 0);
        chk({tag, "_flushing"}, 32'(flushing), 0);
        chk({tag, "_level"}, 32'(fifo_level), 0);
    endtask

    task automatic wait_sel(input logic [1:0] target, input int budget, input bit rand_ready);
        int n = 0;
        while (sel !== target && n < budget) begin
            if (rand_ready) ast_source_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        chk("sel_reached", 32'(sel), 32'(target));
    endtask

    task automatic rand_cycle();
        ast_source_ready = ($urandom_range(0, 3) != 0);
        if ((sent_total - data_total) < int'(DEPTH) && $urandom_range(0, 1) == 1) begin
            sample_in    = rnd_sample();
            sample_valid = 1'b1;
            push_exp(sample_in, 2'b00);
            sent_total++;
        end else begin
            sample_valid = 1'b0;
        end
        tick();
    endtask

    // Stream monitor: hold-under-stall, in-order data, zero beats only while
    // flushing, and exactly FLEN zero transfers before every sel change.
    always @(negedge clk) begin
        if (!reset_n) begin
            zrun       = 0;
            prev_sel   = SEL_FLAT;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 32'(ast_source_valid), 1);
                chk("hold_data", 32'(ast_source_data), 32'(held_data));
                chk("hold_err", 32'(ast_source_error), 32'(held_err));
            end
            if (ast_source_valid && ast_source_ready) begin
                if (ast_source_data == '0) begin
                    chk("zero_flushing", 32'(flushing), 1);
                    chk("zero_err", 32'(ast_source_error), 0);
                    zrun++;
                    zeros_total++;
                end else if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got 0x%0h expected no beat at %0t",
                             ast_source_data, $time);
                end else begin
                    mon_b = exp_q.pop_front();
                    chk("beat_data", 32'(ast_source_data), 32'(mon_b.data));
                    chk("beat_err", 32'(ast_source_error), 32'(mon_b.err));
                    data_total++;
                end
            end
            if (sel !== prev_sel) begin
                chk("flush_len", 32'(zrun), FLEN);
                zrun     = 0;
                prev_sel = sel;
            end
            stall_prev = ast_source_valid && !ast_source_ready;
            held_data  = ast_source_data;
            held_err   = ast_source_error;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          tbl[6];
        logic [DW-1:0] s[10];
        logic [1:0]    cur;
        int            z0;
        int            n;

        // Latency table: three writes with ready high, rows give state after each edge.
        tbl[0] = '{sv: 1'b1, s: 12'h123, rdy: 1'b1, ev: 1'b0, ed: 12'h000, el: 4'd1};
        tbl[1] = '{sv: 1'b1, s: 12'h7FF, rdy: 1'b1, ev: 1'b1, ed: 12'h123, el: 4'd1};
        tbl[2] = '{sv: 1'b1, s: 12'h800, rdy: 1'b1, ev: 1'b1, ed: 12'h7FF, el: 4'd1};
        tbl[3] = '{sv: 1'b0, s: 12'h000, rdy: 1'b1, ev: 1'b1, ed: 12'h800, el: 4'd0};
        tbl[4] = '{sv: 1'b0, s: 12'h000, rdy: 1'b1, ev: 1'b0, ed: 12'h000, el: 4'd0};
        tbl[5] = '{sv: 1'b0, s: 12'h000, rdy: 1'b1, ev: 1'b0, ed: 12'h000, el: 4'd0};

        // Power-on reset.
        #2 reset_n = 1'b0;
        #1 check_idle_outputs("por");
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Latency and ordering via the table.
        for (int i = 0; i < 6; i++) begin
            sample_valid     = tbl[i].sv;
            sample_in        = tbl[i].s;
            ast_source_ready = tbl[i].rdy;
            if (tbl[i].sv) push_exp(tbl[i].s, 2'b00);
            tick();
            chk("tbl_valid", 32'(ast_source_valid), 32'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk("tbl_data", 32'(ast_source_data), 32'(tbl[i].ed));
                chk("tbl_err", 32'(ast_source_error), 0);
            end
            chk("tbl_level", 32'(fifo_level), 32'(tbl[i].el));
        end
        sample_valid = 1'b0;

        // Backpressure: 8 samples during 10 stalled cycles.
        ast_source_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s[i]         = rnd_sample();
            sample_in    = s[i];
            sample_valid = 1'b1;
            push_exp(s[i], 2'b00);
            tick();
        end
        sample_valid = 1'b0;
        tick();
        tick();
        chk("bp_valid", 32'(ast_source_valid), 1);
        chk("bp_data", 32'(ast_source_data), 32'(s[0]));
        chk("bp_level", 32'(fifo_level), 7);
        ast_source_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("bp_nogap", 32'(ast_source_valid), 1);
            tick();
        end
        chk("bp_done_valid", 32'(ast_source_valid), 0);
        chk("bp_drained", 32'(exp_q.size()), 0);

        // Overflow: 10 samples with ready low, the last one is lost.
        ast_source_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            s[i]         = rnd_sample();
            sample_in    = s[i];
            sample_valid = 1'b1;
            if (i < 9) push_exp(s[i], (i == 1) ? ERR_DROP : 2'b00);
            tick();
        end
        sample_valid = 1'b0;
        chk("ovf_level", 32'(fifo_level), 8);
        chk("ovf_head_data", 32'(ast_source_data), 32'(s[0]));
        chk("ovf_head_err", 32'(ast_source_error), 0);
        ast_source_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("ovf_done_valid", 32'(ast_source_valid), 0);
        chk("ovf_done_level", 32'(fifo_level), 0);
        chk("ovf_drained", 32'(exp_q.size()), 0);

        // Select change 0 -> 2 with samples arriving during the flush.
        z0      = zeros_total;
        sel_req = SEL_BANDPASS;
        for (int i = 0; i < 4; i++) begin
            s[i]         = rnd_sample();
            sample_in    = s[i];
            sample_valid = 1'b1;
            push_exp(s[i], 2'b00);
            tick();
        end
        sample_valid = 1'b0;
        chk("sc_flushing", 32'(flushing), 1);
        wait_sel(SEL_BANDPASS, 300, 1'b0);
        chk("sc_zeros", 32'(zeros_total - z0), FLEN);
        for (int i = 0; i < 10; i++) tick();
        chk("sc_resumed", 32'(exp_q.size()), 0);

        // Flush with ready toggling randomly.
        z0      = zeros_total;
        sel_req = SEL_FLAT;
        wait_sel(SEL_FLAT, 1000, 1'b1);
        ast_source_ready = 1'b1;
        chk("bpf_zeros", 32'(zeros_total - z0), FLEN);

        // Select change during a flush: 0 -> 1, then 3 mid-flush.
        z0      = zeros_total;
        sel_req = SEL_LOWPASS;
        for (int i = 0; i < 20; i++) tick();
        sel_req = SEL_HIGHPASS;
        wait_sel(SEL_LOWPASS, 200, 1'b0);
        chk("df_zeros1", 32'(zeros_total - z0), FLEN);
        wait_sel(SEL_HIGHPASS, 200, 1'b0);
        chk("df_zeros2", 32'(zeros_total - z0), 2 * FLEN);

        // Reset in the middle of a flush with samples buffered.
        sel_req = SEL_FLAT;
        for (int i = 0; i < 3; i++) begin
            sample_in    = rnd_sample();
            sample_valid = 1'b1;
            tick();
        end
        sample_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        @(posedge clk);
        #3 reset_n = 1'b0;
        exp_q.delete();
        #1 check_idle_outputs("rst");
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("rst_after_valid", 32'(ast_source_valid), 0);
        chk("rst_after_level", 32'(fifo_level), 0);
        chk("rst_after_sel", 32'(sel), 0);

        // Randomized traffic with periodic select changes.
        sent_total = data_total;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 120; c++) rand_cycle();
            cur     = sel_req + 2'($urandom_range(1, 3));
            sel_req = cur;
            z0      = zeros_total;
            n       = 0;
            while (sel !== cur && n < 2000) begin
                rand_cycle();
                n++;
            end
            chk("rand_sel", 32'(sel), 32'(cur));
            chk("rand_zeros", 32'(zeros_total - z0), FLEN);
        end
        sample_valid     = 1'b0;
        ast_source_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || ast_source_valid) && n < 200) begin
            tick();
            n++;
        end
        chk("rand_drained", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
